// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Purpose  : Shared types and constants for the instruction fetch queue.
//            - word_t        : 32-bit machine word
//            - fetch_entry_t : one queued fetch {instr, pc, npc}
//            - fqstate_t     : fetch control state
//            - HALT_INSTR    : encoding that stops further fetching
// Revision : 1.0  initial release
// ============================================================================
package fetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fqstate_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch buffer between the pc stage / icache and the
//            decode stage. Captures {imemload, imemaddr, rtn_addr} into a
//            small FIFO, throttles pc advance on free space, discards the
//            queue on a redirect flush and stops fetching after a HALT word.
// Ports    :
//   CLK         in   clock
//   nRST        in   asynchronous active-low reset
//   imemaddr    in   current pc
//   rtn_addr    in   pc+4
//   ihit        in   imemload valid for imemaddr this cycle
//   imemload    in   instruction word from icache
//   imemREN     out  instruction read request
//   pc_advance  out  pc may update at this edge
//   flush       in   redirect; discard queue contents
//   dec_ready   in   decode consumes head entry this cycle
//   dec_valid   out  head entry valid
//   dec_instr   out  head instruction
//   dec_pc      out  head pc
//   dec_npc     out  head pc+4
//   count       out  number of occupied entries
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [31:0]              imemaddr,
    input  logic [31:0]              rtn_addr,
    input  logic                     ihit,
    input  logic [31:0]              imemload,
    output logic                     imemREN,
    output logic                     pc_advance,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_npc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fqstate_t            state_q, state_d;
    logic [PTR_W-1:0]    head_q,  head_d;
    logic [PTR_W-1:0]    tail_q,  tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    fetch_entry_t        mem_q [DEPTH];
    fetch_entry_t        mem_d [DEPTH];

    logic                fetching;
    logic                deq;
    logic                enq;
    fetch_entry_t        head_entry;

    // ------------------------------------------------------------------
    // Handshake decode. flush masks both enq and deq so a redirect wins
    // over everything else happening in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        fetching   = (state_q == FETCH);
        head_entry = mem_q[head_q];
        dec_valid  = (count_q != '0);
        deq        = dec_valid & dec_ready & ~flush;
        // A full queue may still accept when the head leaves this cycle.
        enq        = fetching & ihit & ~flush &
                     ((count_q < CNT_W'(DEPTH)) | deq);
        imemREN    = fetching & ~flush;
        pc_advance = enq | flush;
        dec_instr  = head_entry.instr;
        dec_pc     = head_entry.pc;
        dec_npc    = head_entry.npc;
        count      = count_q;
    end

    // ------------------------------------------------------------------
    // Next-state: pointers, occupancy, storage and control state.
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        state_d = state_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            if (enq) begin
                mem_d[tail_q] = '{instr: imemload, pc: imemaddr, npc: rtn_addr};
                tail_d        = tail_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (enq && (imemload == HALT_INSTR)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // The halt was fetched down a path that has now been squashed.
                if (flush) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: directed vector table for
//            the fill / full / flush / halt sequence, a mid-cycle async reset
//            sequence, and randomized traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] imemaddr;
    logic [31:0] rtn_addr;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic        pc_advance;
    logic        flush;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_npc;
    logic [1:0]  count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemaddr   (imemaddr),
        .rtn_addr   (rtn_addr),
        .ihit       (ihit),
        .imemload   (imemload),
        .imemREN    (imemREN),
        .pc_advance (pc_advance),
        .flush      (flush),
        .dec_ready  (dec_ready),
        .dec_valid  (dec_valid),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .dec_npc    (dec_npc),
        .count      (count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit hit, input bit fl, input bit rdy,
                         input logic [31:0] addr, input logic [31:0] ins);
        ihit      = hit;
        flush     = fl;
        dec_ready = rdy;
        imemaddr  = addr;
        rtn_addr  = addr + 32'd4;
        imemload  = ins;
    endtask

    // Hold reset for two cycles, check the reset-state outputs, then
    // release on a falling edge so the next rising edge is the first one.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h1234_5678);
        @(negedge CLK);
        #1;
        chk("rst_imemREN",    32'(imemREN),    32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        chk("rst_dec_valid",  32'(dec_valid),  32'd0);
        chk("rst_count",      32'(count),      32'd0);
        chk("rst_dec_instr",  dec_instr,       32'd0);
        chk("rst_dec_pc",     dec_pc,          32'd0);
        chk("rst_dec_npc",    dec_npc,         32'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          ihit;
        bit          flush;
        bit          rdy;
        logic [31:0] addr;
        logic [31:0] instr;
        bit          e_ren;
        bit          e_adv;
        bit          e_valid;
        logic [1:0]  e_cnt;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam logic [31:0] I0 = 32'h2001_0001;
    localparam logic [31:0] I1 = 32'h2002_0002;
    localparam logic [31:0] I2 = 32'h2003_0003;
    localparam logic [31:0] I3 = 32'h2004_0004;

    vec_t vecs [13];

    // ------------------------------------------------------------------
    // Reference model: queue of entries plus started/halted flags
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    ent_t m_q[$];
    bit   m_started;
    bit   m_halted;

    task automatic model_check(output bit do_enq, output bit do_deq);
        bit fetching, e_valid, e_adv;
        fetching = m_started && !m_halted;
        e_valid  = (m_q.size() != 0);
        do_deq   = e_valid && dec_ready && !flush;
        do_enq   = fetching && ihit && !flush && ((m_q.size() < DEPTH) || do_deq);
        e_adv    = do_enq || flush;
        chk("rnd_imemREN",    32'(imemREN),    32'(fetching && !flush));
        chk("rnd_pc_advance", 32'(pc_advance), 32'(e_adv));
        chk("rnd_dec_valid",  32'(dec_valid),  32'(e_valid));
        chk("rnd_count",      32'(count),      32'(m_q.size()));
        if (e_valid) begin
            chk("rnd_dec_instr", dec_instr, m_q[0].instr);
            chk("rnd_dec_pc",    dec_pc,    m_q[0].pc);
            chk("rnd_dec_npc",   dec_npc,   m_q[0].npc);
        end
    endtask

    task automatic model_update(input bit do_enq, input bit do_deq,
                                input bit fl, input ent_t e);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (fl) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (do_deq) void'(m_q.pop_front());
            if (do_enq) begin
                m_q.push_back(e);
                if (e.instr == HALT) m_halted = 1'b1;
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        //            hit fl rdy addr      instr  ren adv val cnt  e_instr e_pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, I0,   1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00}; // IDLE ignores ihit
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, I0,   1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h00}; // capture 0x0, no bypass
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h04, I1,   1'b1, 1'b1, 1'b1, 2'd1, I0,    32'h00}; // capture 0x4
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h08, I2,   1'b1, 1'b0, 1'b1, 2'd2, I0,    32'h00}; // full, pc holds
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h08, I2,   1'b1, 1'b1, 1'b1, 2'd2, I0,    32'h00}; // deq+enq on full
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0C, I3,   1'b1, 1'b0, 1'b1, 2'd2, I1,    32'h04}; // head now 0x4
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h0C, I3,   1'b0, 1'b1, 1'b1, 2'd2, I1,    32'h04}; // flush drops ihit
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h40, I3,   1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00}; // emptied
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h10, HALT, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h00}; // enqueue halt
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h14, I3,   1'b0, 1'b0, 1'b1, 2'd1, HALT,  32'h10}; // HALTED, ihit ignored
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h14, I3,   1'b0, 1'b0, 1'b1, 2'd1, HALT,  32'h10}; // still HALTED
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h80, I3,   1'b0, 1'b1, 1'b1, 2'd1, HALT,  32'h10}; // flush out of HALTED
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h80, I3,   1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00}; // FETCH again, empty

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ihit, vecs[i].flush, vecs[i].rdy, vecs[i].addr, vecs[i].instr);
            #1;
            chk($sformatf("v%0d_imemREN", i),    32'(imemREN),    32'(vecs[i].e_ren));
            chk($sformatf("v%0d_pc_advance", i), 32'(pc_advance), 32'(vecs[i].e_adv));
            chk($sformatf("v%0d_dec_valid", i),  32'(dec_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d_count", i),      32'(count),      32'(vecs[i].e_cnt));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_dec_instr", i), dec_instr, vecs[i].e_instr);
                chk($sformatf("v%0d_dec_pc", i),    dec_pc,    vecs[i].e_pc);
                chk($sformatf("v%0d_dec_npc", i),   dec_npc,   vecs[i].e_pc + 32'd4);
            end
            @(negedge CLK);
        end

        // Async reset in mid-cycle with one entry queued.
        drive(1'b1, 1'b0, 1'b0, 32'h40, I2);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 32'h44, I3);
        #1;
        chk("ar_count_before", 32'(count),     32'd1);
        chk("ar_valid_before", 32'(dec_valid), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("ar_dec_valid", 32'(dec_valid), 32'd0);
        chk("ar_count",     32'(count),     32'd0);
        chk("ar_imemREN",   32'(imemREN),   32'd0);
        chk("ar_dec_instr", dec_instr,      32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        m_q.delete();
        m_started = 1'b0;
        m_halted  = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit   de, dd, fl;
            ent_t e;
            if ($urandom_range(0, 499) == 0) begin
                // Short async reset pulse released before the next rising edge.
                #1;
                nRST = 1'b0;
                #1;
                chk("rnd_async_count", 32'(count),     32'd0);
                chk("rnd_async_valid", 32'(dec_valid), 32'd0);
                nRST = 1'b1;
                m_q.delete();
                m_started = 1'b0;
                m_halted  = 1'b0;
            end
            fl      = ($urandom_range(0, 9) == 0);
            e.pc    = $urandom & 32'hFFFF_FFFC;
            e.npc   = e.pc + 32'd4;
            e.instr = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            drive($urandom_range(0, 9) < 7, fl, $urandom_range(0, 9) < 6, e.pc, e.instr);
            #1;
            model_check(de, dd);
            @(negedge CLK);
            model_update(de, dd, fl, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
